// File: rtl/dcp_pkg.sv
// Shared types and default raster/FIFO constants for the DCP video output stage.
package dcp_pkg;

  localparam int unsigned RGB_W = 24;
  localparam logic [RGB_W-1:0] BLACK = 24'h0;

  typedef enum logic {
    WAIT_FILL,
    RUN
  } state_t;

  // 640x480 defaults
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_H_FP        = 16;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_BP        = 48;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_V_FP        = 10;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_BP        = 33;
  localparam int unsigned DEF_FIFO_DEPTH  = 2048;
  localparam int unsigned DEF_START_LEVEL = 640;

endpackage

// File: rtl/dcp_sync_fifo.sv
// Single-clock pixel FIFO with registered read port and occupancy count.
module dcp_sync_fifo
  import dcp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH = RGB_W
) (
  input  logic                           pixelclk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    rd_ok = rd_en && !empty;
    wr_ok = wr_en && (!full || rd_ok);
  end

  always_ff @(posedge pixelclk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // rd_data is zero on cycles without a read so it can drive a blanked pixel directly
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      rd_data <= rd_ok ? mem[rd_ptr] : '0;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcp_vid_out.sv
// Elastic output stage: buffers the defog core's pixel stream and replays it
// onto a free-running raster with active-high DE/HSYNC/VSYNC.
module dcp_vid_out
  import dcp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned START_LEVEL = DEF_START_LEVEL
) (
  input  logic                              pixelclk,
  input  logic                              reset,
  input  logic [RGB_W-1:0]                  i_defog_rgb,
  input  logic                              i_data_valid,
  output logic [RGB_W-1:0]                  o_rgb,
  output logic                              o_de,
  output logic                              o_hs,
  output logic                              o_vs,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fill,
  output logic                              o_underflow,
  output logic                              o_overflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] START  = CW'(START_LEVEL);

  state_t        state;
  state_t        state_next;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          pre_de;
  logic          pre_hs;
  logic          pre_vs;
  logic          rd_en;
  logic          wr_en;
  logic          fifo_empty;
  logic          fifo_full;

  dcp_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) u_fifo (
    .pixelclk (pixelclk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (i_defog_rgb),
    .rd_en    (rd_en),
    .rd_data  (o_rgb),
    .count    (o_fill),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Counters sit at 0 while filling, so pre-signals must be gated by RUN
  always_comb begin
    state_next = state;
    pre_de     = 1'b0;
    pre_hs     = 1'b0;
    pre_vs     = 1'b0;
    if (state == WAIT_FILL) begin
      if (o_fill >= START) state_next = RUN;
    end else begin
      pre_de = (h < H_ACT) && (v < V_ACT);
      pre_hs = (h >= HS_BEG) && (h < HS_END);
      pre_vs = (v >= VS_BEG) && (v < VS_END);
    end
    rd_en = pre_de && !fifo_empty;
    wr_en = i_data_valid && (!fifo_full || rd_en);
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state <= WAIT_FILL;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_next;
      if (state == RUN) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // Timing delayed one stage to line up with the FIFO's registered read data
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_de        <= 1'b0;
      o_hs        <= 1'b0;
      o_vs        <= 1'b0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_de <= pre_de;
      o_hs <= pre_hs;
      o_vs <= pre_vs;
      if (pre_de && fifo_empty)    o_underflow <= 1'b1;
      if (i_data_valid && !wr_en)  o_overflow  <= 1'b1;
    end
  end

endmodule
